// File: rtl/voice_alloc_pkg.sv
// Shared build settings and sizing helpers for the voice allocator.
// Build macros: OSC_VOICES, MIDI_PAYLOAD_BITS, VOICE_AGE_BITS.
// VOICE_STEAL_EN (left undefined by default) makes a note-on with every
// voice busy take over the oldest voice instead of being dropped.

`ifndef OSC_VOICES
`define OSC_VOICES 4
`endif

`ifndef MIDI_PAYLOAD_BITS
`define MIDI_PAYLOAD_BITS 8
`endif

`ifndef VOICE_AGE_BITS
`define VOICE_AGE_BITS $clog2(`OSC_VOICES)
`endif

package voice_alloc_pkg;

    localparam int DEF_VOICES    = `OSC_VOICES;
    localparam int DEF_NOTE_BITS = `MIDI_PAYLOAD_BITS;
    localparam int DEF_AGE_BITS  = `VOICE_AGE_BITS;

    // Index width for a voice number; at least one bit even for tiny stacks.
    function automatic int idxBits(input int voices);
        return (voices > 1) ? $clog2(voices) : 1;
    endfunction

endpackage

// File: rtl/voice_find.sv
// Combinational lookup over the voice table: note match, first free voice
// and oldest enabled voice. Every search favours the lowest index.

module voice_find
    import voice_alloc_pkg::*;
#(
    parameter int VOICES    = DEF_VOICES,
    parameter int NOTE_BITS = DEF_NOTE_BITS,
    parameter int AGE_BITS  = DEF_AGE_BITS,
    parameter int IDX_BITS  = idxBits(VOICES)
) (
    input  logic [VOICES-1:0]           en,
    input  logic [VOICES*NOTE_BITS-1:0] notes,
    input  logic [VOICES*AGE_BITS-1:0]  ages,
    input  logic [NOTE_BITS-1:0]        note,
    output logic                        matchHit,
    output logic [IDX_BITS-1:0]         matchIdx,
    output logic                        freeHit,
    output logic [IDX_BITS-1:0]         freeIdx,
    output logic [IDX_BITS-1:0]         oldestIdx
);

    logic                oldestHit;
    logic [AGE_BITS-1:0] oldestAge;

    // Priority search; descending loops let the lowest index win the last write.
    always_comb begin
        matchHit  = 1'b0;
        matchIdx  = '0;
        freeHit   = 1'b0;
        freeIdx   = '0;
        oldestIdx = '0;
        oldestHit = 1'b0;
        oldestAge = '0;
        for (int v = VOICES - 1; v >= 0; v--) begin
            if (en[v] && (notes[v*NOTE_BITS +: NOTE_BITS] == note)) begin
                matchHit = 1'b1;
                matchIdx = IDX_BITS'(v);
            end
            if (!en[v]) begin
                freeHit = 1'b1;
                freeIdx = IDX_BITS'(v);
            end
        end
        // Strictly-greater compare keeps ties on the lowest index.
        for (int v = 0; v < VOICES; v++) begin
            if (en[v] && (!oldestHit || (ages[v*AGE_BITS +: AGE_BITS] > oldestAge))) begin
                oldestHit = 1'b1;
                oldestAge = ages[v*AGE_BITS +: AGE_BITS];
                oldestIdx = IDX_BITS'(v);
            end
        end
    end

endmodule

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: maps note-on/note-off strobes onto a fixed
// oscillator voice table. Every event is applied in its strobe cycle and
// shows on the outputs one clock later.
// Build option VOICE_STEAL_EN: take over the oldest voice when all voices
// are busy. Without it, that note-on is dropped and dropStrb_o pulses.

module voice_alloc
    import voice_alloc_pkg::*;
#(
    parameter int VOICES    = DEF_VOICES,
    parameter int NOTE_BITS = DEF_NOTE_BITS,
    parameter int AGE_BITS  = $clog2(VOICES)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NOTE_BITS-1:0]          note_i,
    input  logic                          noteOnStrb_i,
    input  logic                          noteOffStrb_i,
    output logic [VOICES*NOTE_BITS-1:0]   voiceNote_o,
    output logic [VOICES-1:0]             voiceEn_o,
    output logic [VOICES-1:0]             voiceRetrig_o,
    output logic [$clog2(VOICES+1)-1:0]   activeCount_o,
    output logic                          dropStrb_o
);

    localparam int IDX_BITS = idxBits(VOICES);
    localparam int CNT_BITS = $clog2(VOICES + 1);
    localparam logic [AGE_BITS-1:0] AGE_MAX = AGE_BITS'(VOICES - 1);

    logic [VOICES-1:0]           enQ, enD;
    logic [VOICES*NOTE_BITS-1:0] noteQ, noteD;
    logic [VOICES*AGE_BITS-1:0]  ageQ, ageD;
    logic [VOICES-1:0]           retrigQ, retrigD;
    logic                        dropQ, dropD;
    logic [CNT_BITS-1:0]         countQ, countD;

    logic                matchHit, freeHit;
    logic [IDX_BITS-1:0] matchIdx, freeIdx, oldestIdx;
    logic                tgtHit;
    logic [IDX_BITS-1:0] tgtIdx;

    voice_find #(
        .VOICES    (VOICES),
        .NOTE_BITS (NOTE_BITS),
        .AGE_BITS  (AGE_BITS),
        .IDX_BITS  (IDX_BITS)
    ) uFind (
        .en        (enQ),
        .notes     (noteQ),
        .ages      (ageQ),
        .note      (note_i),
        .matchHit  (matchHit),
        .matchIdx  (matchIdx),
        .freeHit   (freeHit),
        .freeIdx   (freeIdx),
        .oldestIdx (oldestIdx)
    );

`ifndef VOICE_STEAL_EN
    // The oldest-voice search only matters when stealing is built in.
    logic unusedOldest;
    assign unusedOldest = ^oldestIdx;
`endif

    // Next voice table: note-on wins over a simultaneous note-off.
    always_comb begin
        enD     = enQ;
        noteD   = noteQ;
        ageD    = ageQ;
        retrigD = '0;
        dropD   = 1'b0;
        tgtHit  = 1'b0;
        tgtIdx  = '0;
        countD  = '0;

        if (noteOnStrb_i) begin
            if (matchHit) begin
                tgtHit = 1'b1;
                tgtIdx = matchIdx;
            end else if (freeHit) begin
                tgtHit = 1'b1;
                tgtIdx = freeIdx;
            end else begin
`ifdef VOICE_STEAL_EN
                tgtHit = 1'b1;
                tgtIdx = oldestIdx;
`else
                dropD  = 1'b1;
`endif
            end

            if (tgtHit) begin
                for (int v = 0; v < VOICES; v++) begin
                    if (IDX_BITS'(v) == tgtIdx) begin
                        enD[v]                          = 1'b1;
                        noteD[v*NOTE_BITS +: NOTE_BITS] = note_i;
                        ageD[v*AGE_BITS +: AGE_BITS]    = '0;
                        retrigD[v]                      = 1'b1;
                    end else if (enQ[v] && (ageQ[v*AGE_BITS +: AGE_BITS] != AGE_MAX)) begin
                        ageD[v*AGE_BITS +: AGE_BITS] = ageQ[v*AGE_BITS +: AGE_BITS] + 1'b1;
                    end
                end
            end
        end else if (noteOffStrb_i && matchHit) begin
            enD[matchIdx] = 1'b0;
        end

        for (int v = 0; v < VOICES; v++) begin
            countD = countD + CNT_BITS'(enD[v]);
        end
    end

    // Voice table and output registers; reset clears everything at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            enQ     <= '0;
            noteQ   <= '0;
            ageQ    <= '0;
            retrigQ <= '0;
            dropQ   <= 1'b0;
            countQ  <= '0;
        end else begin
            enQ     <= enD;
            noteQ   <= noteD;
            ageQ    <= ageD;
            retrigQ <= retrigD;
            dropQ   <= dropD;
            countQ  <= countD;
        end
    end

    assign voiceNote_o   = noteQ;
    assign voiceEn_o     = enQ;
    assign voiceRetrig_o = retrigQ;
    assign activeCount_o = countQ;
    assign dropStrb_o    = dropQ;

endmodule

// File: tb/tb_voice_alloc.sv
// Self-checking bench for voice_alloc with the default 4 voices x 8 bits.
// Directed vector table, hand-written reset sequence, then random traffic
// compared against a behavioural voice-table model.

module tb_voice_alloc;

    localparam int NV = 4;
    localparam int NB = 8;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic [NB-1:0]   note_i = '0;
    logic            noteOnStrb_i = 1'b0;
    logic            noteOffStrb_i = 1'b0;
    logic [NV*NB-1:0] voiceNote_o;
    logic [NV-1:0]   voiceEn_o;
    logic [NV-1:0]   voiceRetrig_o;
    logic [2:0]      activeCount_o;
    logic            dropStrb_o;

    int nChecks = 0;
    int nErrors = 0;

    voice_alloc dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .note_i        (note_i),
        .noteOnStrb_i  (noteOnStrb_i),
        .noteOffStrb_i (noteOffStrb_i),
        .voiceNote_o   (voiceNote_o),
        .voiceEn_o     (voiceEn_o),
        .voiceRetrig_o (voiceRetrig_o),
        .activeCount_o (activeCount_o),
        .dropStrb_o    (dropStrb_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: plain arrays of voice state.
    bit           mEn[NV];
    int           mNote[NV];
    int           mAge[NV];
    logic [NV-1:0] mRetrig;
    bit           mDrop;

    task automatic modelReset();
        for (int v = 0; v < NV; v++) begin
            mEn[v] = 0; mNote[v] = 0; mAge[v] = 0;
        end
        mRetrig = '0;
        mDrop = 0;
    endtask

    task automatic modelStep(input bit on, input bit off, input int n);
        int tgt;
        int best;
        tgt = -1;
        best = -1;
        mRetrig = '0;
        mDrop = 0;
        if (on) begin
            for (int v = 0; v < NV; v++)
                if (tgt < 0 && mEn[v] && mNote[v] == n) tgt = v;
            for (int v = 0; v < NV; v++)
                if (tgt < 0 && !mEn[v]) tgt = v;
            if (tgt < 0) begin
`ifdef VOICE_STEAL_EN
                for (int v = 0; v < NV; v++)
                    if (best < 0 || mAge[v] > mAge[best]) best = v;
                tgt = best;
`else
                mDrop = 1;
`endif
            end
            if (tgt >= 0) begin
                for (int v = 0; v < NV; v++)
                    if (v != tgt && mEn[v] && mAge[v] < NV - 1) mAge[v]++;
                mEn[tgt] = 1;
                mNote[tgt] = n;
                mAge[tgt] = 0;
                mRetrig[tgt] = 1'b1;
            end
        end else if (off) begin
            for (int v = 0; v < NV; v++)
                if (tgt < 0 && mEn[v] && mNote[v] == n) tgt = v;
            if (tgt >= 0) mEn[tgt] = 0;
        end
    endtask

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkModel(input string tag);
        logic [NV*NB-1:0] eNotes;
        logic [NV-1:0]    eEn;
        int               eCnt;
        eCnt = 0;
        for (int v = 0; v < NV; v++) begin
            eNotes[v*NB +: NB] = NB'(mNote[v]);
            eEn[v] = mEn[v];
            eCnt += int'(mEn[v]);
        end
        checkVal({tag, ".en"},     64'(voiceEn_o),     64'(eEn));
        checkVal({tag, ".notes"},  64'(voiceNote_o),   64'(eNotes));
        checkVal({tag, ".retrig"}, 64'(voiceRetrig_o), 64'(mRetrig));
        checkVal({tag, ".count"},  64'(activeCount_o), 64'(eCnt));
        checkVal({tag, ".drop"},   64'(dropStrb_o),    64'(mDrop));
    endtask

    // Apply one strobe cycle (called #1 after a rising edge), then sample #1 after the next.
    task automatic drive(input bit on, input bit off, input int n);
        noteOnStrb_i  = on;
        noteOffStrb_i = off;
        note_i        = NB'(n);
        @(posedge clk_i);
        #1;
        noteOnStrb_i  = 1'b0;
        noteOffStrb_i = 1'b0;
        modelStep(on, off, n);
    endtask

    task automatic doReset();
        rst_i = 1'b1;
        modelReset();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    typedef struct {
        bit          on;
        bit          off;
        int          note;
        logic [3:0]  en;
        logic [31:0] notes;
        logic [3:0]  retrig;
        bit          drop;
        int          cnt;
    } vec_t;

    vec_t tbl[10];

    initial begin
`ifdef VOICE_STEAL_EN
        logic [31:0] fullNotes = 32'h46404348;
        logic [3:0]  fullRetrig = 4'b0001;
        bit          fullDrop = 0;
`else
        logic [31:0] fullNotes = 32'h4640433C;
        logic [3:0]  fullRetrig = 4'b0000;
        bit          fullDrop = 1;
`endif
        tbl[0] = '{1, 0, 60, 4'b0001, 32'h0000003C, 4'b0001, 0, 1};
        tbl[1] = '{1, 0, 62, 4'b0011, 32'h00003E3C, 4'b0010, 0, 2};
        tbl[2] = '{1, 0, 64, 4'b0111, 32'h00403E3C, 4'b0100, 0, 3};
        tbl[3] = '{0, 1, 62, 4'b0101, 32'h00403E3C, 4'b0000, 0, 2};
        tbl[4] = '{1, 0, 67, 4'b0111, 32'h0040433C, 4'b0010, 0, 3};
        tbl[5] = '{1, 0, 67, 4'b0111, 32'h0040433C, 4'b0010, 0, 3};
        tbl[6] = '{0, 1, 61, 4'b0111, 32'h0040433C, 4'b0000, 0, 3};
        tbl[7] = '{1, 1, 70, 4'b1111, 32'h4640433C, 4'b1000, 0, 4};
        tbl[8] = '{1, 0, 72, 4'b1111, fullNotes,    fullRetrig, fullDrop, 4};
        tbl[9] = '{0, 0, 0,  4'b1111, fullNotes,    4'b0000, 0, 4};

        // Reset state, sampled while reset is held.
        modelReset();
        #2;
        checkVal("reset.en",     64'(voiceEn_o),     64'h0);
        checkVal("reset.notes",  64'(voiceNote_o),   64'h0);
        checkVal("reset.retrig", 64'(voiceRetrig_o), 64'h0);
        checkVal("reset.count",  64'(activeCount_o), 64'h0);
        checkVal("reset.drop",   64'(dropStrb_o),    64'h0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Directed vectors (row 7 also exercises the same-cycle on/off case).
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].on, tbl[i].off, tbl[i].note);
            checkVal($sformatf("vec%0d.en", i),     64'(voiceEn_o),     64'(tbl[i].en));
            checkVal($sformatf("vec%0d.notes", i),  64'(voiceNote_o),   64'(tbl[i].notes));
            checkVal($sformatf("vec%0d.retrig", i), 64'(voiceRetrig_o), 64'(tbl[i].retrig));
            checkVal($sformatf("vec%0d.drop", i),   64'(dropStrb_o),    64'(tbl[i].drop));
            checkVal($sformatf("vec%0d.count", i),  64'(activeCount_o), 64'(tbl[i].cnt));
            checkModel($sformatf("vec%0d.model", i));
        end

        // Asynchronous reset mid-sequence with three voices active.
        doReset();
        drive(1, 0, 60);
        drive(1, 0, 62);
        drive(1, 0, 64);
        checkVal("pre_rst.count", 64'(activeCount_o), 64'd3);
        #3;
        rst_i = 1'b1;
        #1;
        modelReset();
        checkVal("async_rst.en",    64'(voiceEn_o),     64'h0);
        checkVal("async_rst.notes", 64'(voiceNote_o),   64'h0);
        checkVal("async_rst.count", 64'(activeCount_o), 64'h0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        drive(1, 0, 50);
        checkVal("post_rst.en",    64'(voiceEn_o),   64'b0001);
        checkVal("post_rst.note0", 64'(voiceNote_o), 64'h32);
        checkModel("post_rst");

        // Randomised traffic against the model; a narrow note range forces full/match cases.
        for (int c = 0; c < 1500; c++) begin
            int r;
            bit on;
            bit off;
            r = int'($urandom_range(0, 99));
            on  = (r < 55) || (r >= 90);
            off = (r >= 55);
            drive(on, off, int'($urandom_range(60, 66)));
            checkModel($sformatf("rand%0d", c));
        end

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
